// File: rtl/nios2system_cpu_debug_ocimem_ctrl.sv
// OCI debug RAM controller: arbitrates JTAG monitor accesses (MonAReg/MonDReg) and
// CPU Avalon accesses onto a single-port RAM with one-cycle registered read latency.
module nios2system_cpu_debug_ocimem_ctrl #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW-1:0] address,
  input  logic          chipselect,
  input  logic          read,
  input  logic          write,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  input  logic          debugaccess,
  output logic [31:0]   readdata,
  output logic          waitrequest,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_byteen,
  output logic          ram_wren,
  input  logic [31:0]   ram_rdata,
  output logic [AW-1:0] MonAReg,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CRD  = 2'd1;
  localparam logic [1:0] CACK = 2'd2;
  localparam logic [1:0] JRD  = 2'd3;

  localparam logic [AW-1:0] AddrOne = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic          pend_q, pend_d;
  logic          pend_wr_q, pend_wr_d;
  logic          pend_inc_q, pend_inc_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic [AW-1:0] mon_a_q, mon_a_d;
  logic [31:0]   mon_d_q, mon_d_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;

  logic          strobe_any;
  logic          cpu_req;
  logic          wren_c;

  assign strobe_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign cpu_req    = chipselect & (read | write);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_wr_d   = pend_wr_q;
    pend_inc_d  = pend_inc_q;
    pend_data_d = pend_data_q;
    mon_a_d     = mon_a_q;
    mon_d_d     = mon_d_q;
    readdata_d  = readdata_q;
    ready_d     = ready_q;
    error_d     = error_q;
    ram_addr    = address;
    ram_wdata   = writedata;
    ram_byteen  = byteenable;
    wren_c      = 1'b0;

    // Strobe intake: a single-entry queue, so anything arriving while it is full is lost.
    if (strobe_any) begin
      if (pend_q) begin
        error_d = 1'b1;
      end else begin
        error_d = 1'b0;
        if (take_action_ocimem_b) begin
          pend_d      = 1'b1;
          pend_wr_d   = 1'b1;
          pend_inc_d  = 1'b1;
          pend_data_d = jdo[34:3];
          ready_d     = 1'b0;
        end else if (take_action_ocimem_a) begin
          mon_a_d    = jdo[AW+17:18];
          pend_d     = jdo[17];
          pend_wr_d  = 1'b0;
          pend_inc_d = 1'b0;
          if (jdo[17]) begin
            ready_d = 1'b0;
          end
        end else begin
          pend_d     = 1'b1;
          pend_wr_d  = 1'b0;
          pend_inc_d = 1'b1;
          ready_d    = 1'b0;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          ram_addr = mon_a_q;
          if (pend_wr_q) begin
            ram_wdata  = pend_data_q;
            ram_byteen = 4'hF;
            wren_c     = 1'b1;
            pend_d     = 1'b0;
            ready_d    = 1'b1;
            if (pend_inc_q) begin
              mon_a_d = mon_a_q + AddrOne;
            end
          end else begin
            state_d = JRD;
          end
        end else if (strobe_any) begin
          // A strobe landing this cycle becomes pending next cycle; hold the CPU off so
          // the JTAG operation goes first.
          state_d = IDLE;
        end else if (cpu_req) begin
          if (read) begin
            state_d = CRD;
          end else begin
            wren_c  = debugaccess;
            state_d = CACK;
          end
        end
      end
      CRD: begin
        readdata_d = ram_rdata;
        state_d    = CACK;
      end
      CACK: begin
        state_d = IDLE;
      end
      JRD: begin
        mon_d_d = ram_rdata;
        ready_d = 1'b1;
        pend_d  = 1'b0;
        if (pend_inc_q) begin
          mon_a_d = mon_a_q + AddrOne;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_inc_q  <= 1'b0;
      pend_data_q <= 32'h0;
      mon_a_q     <= '0;
      mon_d_q     <= 32'h0;
      readdata_q  <= 32'h0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_wr_q   <= pend_wr_d;
      pend_inc_q  <= pend_inc_d;
      pend_data_q <= pend_data_d;
      mon_a_q     <= mon_a_d;
      mon_d_q     <= mon_d_d;
      readdata_q  <= readdata_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  // Gate with reset so a CPU write presented during reset cannot reach the RAM.
  assign ram_wren      = wren_c & ~reset;
  assign waitrequest   = cpu_req & (state_q != CACK);
  assign readdata      = readdata_q;
  assign MonAReg       = mon_a_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_nios2system_cpu_debug_ocimem_ctrl.sv
// Bench for the OCI RAM controller: a RAM behind the DUT plus an abstract monitor model.
module tb_nios2system_cpu_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [7:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        debugaccess = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteen;
  logic        ram_wren;
  logic [31:0] ram_rdata;
  logic [7:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  nios2system_cpu_debug_ocimem_ctrl #(.AW(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .debugaccess(debugaccess),
    .readdata(readdata), .waitrequest(waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byteen(ram_byteen),
    .ram_wren(ram_wren), .ram_rdata(ram_rdata),
    .MonAReg(MonAReg), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: what the RAM and monitor registers must hold.
  logic [31:0] exp_mem [256];
  logic [7:0]  exp_mona = '0;
  logic [31:0] exp_mond = '0;

  // RAM attached to the DUT; bd_load copies the reference image in (setup only).
  logic [31:0] ram [256];
  logic        bd_load = 1'b0;
  int          wren_cnt = 0;

  always @(posedge clk) begin
    if (bd_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= exp_mem[i];
    end else if (ram_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_byteen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    ram_rdata <= ram[ram_addr];
    if (ram_wren) wren_cnt <= wren_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_strobe(input logic sb, input logic sa, input logic sn,
                             input logic [37:0] j);
    jdo = j;
    take_action_ocimem_b = sb;
    take_action_ocimem_a = sa;
    take_no_action_ocimem_a = sn;
    step();
    take_action_ocimem_b = 1'b0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 10; i++) begin
      if (monitor_ready) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL %s: monitor_ready never rose within 10 cycles", name);
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[25:18] = a;
    j[17] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // One CPU access; optionally raises ocimem_b in the same first cycle.
  task automatic cpu_access(input logic rd, input logic [7:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic dbg,
                            input logic jb, input logic [31:0] jd,
                            output int nwait, output logic [31:0] rdata);
    logic done;
    chipselect = 1'b1; read = rd; write = ~rd; address = a;
    writedata = wd; byteenable = be; debugaccess = dbg;
    if (jb) begin
      jdo = jdo_data(jd);
      take_action_ocimem_b = 1'b1;
    end
    nwait = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!waitrequest) begin
        done = 1'b1;
      end else begin
        nwait++;
        @(posedge clk);
        #1;
        take_action_ocimem_b = 1'b0;
      end
    end
    rdata = readdata;
    @(posedge clk);
    #1;
    take_action_ocimem_b = 1'b0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; debugaccess = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL cpu_timeout: waitrequest still high after 20 cycles at addr %0h", a);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (MonAReg !== 8'h0 || MonDReg !== 32'h0 || readdata !== 32'h0 ||
        monitor_ready !== 1'b0 || monitor_error !== 1'b0 || ram_wren !== 1'b0 ||
        waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL %s: got a=%h d=%h rd=%h rdy=%b err=%b wren=%b wait=%b, want all zero",
               name, MonAReg, MonDReg, readdata, monitor_ready, monitor_error, ram_wren,
               waitrequest);
    end
  endtask

  task automatic test_reset();
    step();
    check_reset_outputs("reset_state");
    step();
    reset = 1'b0;
    step();
    check_reset_outputs("after_reset_release");
  endtask

  task automatic test_load_read();
    jtag_strobe(1'b0, 1'b1, 1'b0, jdo_addr(8'h10, 1'b1));
    exp_mona = 8'h10;
    checks++;
    if (MonAReg !== 8'h10 || monitor_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_addr: MonAReg=%h ready=%b, want 10 and 0", MonAReg, monitor_ready);
    end
    step();
    step();
    exp_mond = exp_mem[8'h10];
    checks++;
    if (MonDReg !== exp_mond || monitor_ready !== 1'b1 || MonAReg !== 8'h10) begin
      errors++;
      $display("FAIL load_read: MonDReg=%h ready=%b a=%h, want %h 1 10",
               MonDReg, monitor_ready, MonAReg, exp_mond);
    end
  endtask

  task automatic test_write_wrap();
    jtag_strobe(1'b0, 1'b1, 1'b0, jdo_addr(8'hFE, 1'b0));
    exp_mona = 8'hFE;
    for (int k = 1; k <= 3; k++) begin
      logic [31:0] d;
      d = 32'hA5A5_0000 + 32'(k);
      jtag_strobe(1'b1, 1'b0, 1'b0, jdo_data(d));
      wait_ready("write_wrap_ready");
      exp_mem[exp_mona] = d;
      exp_mona = exp_mona + 8'd1;
    end
    checks++;
    if (ram[8'hFE] !== 32'hA5A5_0001 || ram[8'hFF] !== 32'hA5A5_0002 ||
        ram[8'h00] !== 32'hA5A5_0003 || MonAReg !== 8'h01) begin
      errors++;
      $display("FAIL write_wrap: FE=%h FF=%h 00=%h a=%h, want A5A50001..3 and 01",
               ram[8'hFE], ram[8'hFF], ram[8'h00], MonAReg);
    end
  endtask

  task automatic test_random_jtag();
    for (int n = 0; n < 24; n++) begin
      int kind;
      logic [31:0] d;
      logic [7:0]  a;
      logic        rdbit;
      kind = $urandom_range(2);
      d = $urandom;
      a = 8'($urandom);
      rdbit = 1'($urandom);
      if (kind == 0) begin
        jtag_strobe(1'b1, 1'b0, 1'b0, jdo_data(d));
        wait_ready("rand_write_ready");
        exp_mem[exp_mona] = d;
        exp_mona = exp_mona + 8'd1;
      end else if (kind == 1) begin
        jtag_strobe(1'b0, 1'b1, 1'b0, jdo_addr(a, rdbit));
        exp_mona = a;
        if (rdbit) begin
          wait_ready("rand_load_ready");
          exp_mond = exp_mem[a];
        end
      end else begin
        jtag_strobe(1'b0, 1'b0, 1'b1, '0);
        wait_ready("rand_read_ready");
        exp_mond = exp_mem[exp_mona];
        exp_mona = exp_mona + 8'd1;
      end
      checks++;
      if (MonAReg !== exp_mona || MonDReg !== exp_mond || monitor_error !== 1'b0) begin
        errors++;
        $display("FAIL rand_jtag[%0d] kind %0d: a=%h d=%h err=%b, want a=%h d=%h err=0",
                 n, kind, MonAReg, MonDReg, monitor_error, exp_mona, exp_mond);
      end
    end
  endtask

  task automatic test_cpu_read();
    int nw;
    logic [31:0] rd;
    cpu_access(1'b1, 8'h05, '0, 4'hF, 1'b0, 1'b0, '0, nw, rd);
    checks++;
    if (nw != 2 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cpu_read_05: waits=%0d data=%h, want 2 DEADBEEF", nw, rd);
    end
  endtask

  task automatic test_cpu_write();
    int nw;
    logic [31:0] rd;
    logic [31:0] d;
    int w0;
    d = $urandom;
    w0 = wren_cnt;
    cpu_access(1'b0, 8'h07, d, 4'hF, 1'b0, 1'b0, '0, nw, rd);
    checks++;
    if (nw != 1 || ram[8'h07] !== exp_mem[8'h07] || wren_cnt != w0) begin
      errors++;
      $display("FAIL cpu_write_nodbg: waits=%0d ram=%h wrens=%0d, want 1 %h 0",
               nw, ram[8'h07], wren_cnt - w0, exp_mem[8'h07]);
    end
    cpu_access(1'b0, 8'h07, d, 4'b0011, 1'b1, 1'b0, '0, nw, rd);
    exp_mem[8'h07][15:0] = d[15:0];
    checks++;
    if (nw != 1 || ram[8'h07] !== exp_mem[8'h07] || wren_cnt != w0 + 1) begin
      errors++;
      $display("FAIL cpu_write_be0011: waits=%0d ram=%h wrens=%0d, want 1 %h 1",
               nw, ram[8'h07], wren_cnt - w0, exp_mem[8'h07]);
    end
    // Random mix of CPU reads and writes against the reference image.
    for (int n = 0; n < 16; n++) begin
      logic        isrd, dbg;
      logic [7:0]  a;
      logic [3:0]  be;
      isrd = 1'($urandom);
      dbg = 1'($urandom);
      a = 8'($urandom);
      be = 4'($urandom);
      d = $urandom;
      cpu_access(isrd, a, d, be, dbg, 1'b0, '0, nw, rd);
      if (isrd) begin
        checks++;
        if (nw != 2 || rd !== exp_mem[a]) begin
          errors++;
          $display("FAIL cpu_rand_read[%0d]: waits=%0d data=%h, want 2 %h",
                   n, nw, rd, exp_mem[a]);
        end
      end else begin
        if (dbg) begin
          for (int b = 0; b < 4; b++) if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
        end
        checks++;
        if (nw != 1 || ram[a] !== exp_mem[a]) begin
          errors++;
          $display("FAIL cpu_rand_write[%0d]: waits=%0d ram=%h, want 1 %h",
                   n, nw, ram[a], exp_mem[a]);
        end
      end
    end
  endtask

  task automatic test_conflict();
    int nw;
    logic [31:0] rd;
    logic [31:0] d;
    logic [7:0]  m;
    logic [7:0]  m2;
    d = $urandom;
    m = exp_mona;
    // CPU reads the very word the JTAG write targets: seeing d proves the write went first.
    cpu_access(1'b1, m, '0, 4'hF, 1'b0, 1'b1, d, nw, rd);
    exp_mem[m] = d;
    exp_mona = m + 8'd1;
    checks++;
    if (nw != 4 || rd !== d || MonAReg !== exp_mona || ram[m] !== d) begin
      errors++;
      $display("FAIL jtag_vs_cpu: waits=%0d data=%h a=%h ram=%h, want 4 %h %h %h",
               nw, rd, MonAReg, ram[m], d, exp_mona, d);
    end
    // A second strobe while one is pending is lost and flags an error.
    m2 = exp_mona ^ 8'h5A;
    jtag_strobe(1'b0, 1'b0, 1'b1, '0);
    jtag_strobe(1'b0, 1'b1, 1'b0, jdo_addr(m2, 1'b0));
    checks++;
    if (monitor_error !== 1'b1 || MonAReg !== exp_mona) begin
      errors++;
      $display("FAIL drop_strobe: err=%b a=%h, want 1 %h", monitor_error, MonAReg, exp_mona);
    end
    wait_ready("drop_read_ready");
    exp_mond = exp_mem[exp_mona];
    exp_mona = exp_mona + 8'd1;
    checks++;
    if (MonDReg !== exp_mond || MonAReg !== exp_mona || monitor_error !== 1'b1) begin
      errors++;
      $display("FAIL drop_keeps_op: d=%h a=%h err=%b, want %h %h 1",
               MonDReg, MonAReg, monitor_error, exp_mond, exp_mona);
    end
    jtag_strobe(1'b0, 1'b1, 1'b0, jdo_addr(8'h30, 1'b0));
    exp_mona = 8'h30;
    checks++;
    if (monitor_error !== 1'b0 || MonAReg !== 8'h30) begin
      errors++;
      $display("FAIL error_clear: err=%b a=%h, want 0 30", monitor_error, MonAReg);
    end
    // All three strobes at once: the write wins, its address field is ignored.
    jtag_strobe(1'b1, 1'b1, 1'b1, jdo_data(32'h1234_5678));
    wait_ready("prio_ready");
    exp_mem[8'h30] = 32'h1234_5678;
    exp_mona = 8'h31;
    checks++;
    if (MonAReg !== 8'h31 || ram[8'h30] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL strobe_priority: a=%h ram30=%h, want 31 12345678", MonAReg, ram[8'h30]);
    end
  endtask

  task automatic test_image();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ram_image: %0d words differ, want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 8'h03;
    step();
    // Now in CRD; queue a JTAG write then hit reset before the clock edge.
    jdo = jdo_data(32'hCAFE_F00D);
    take_action_ocimem_b = 1'b1;
    w0 = wren_cnt;
    #2;
    reset = 1'b1;
    #1;
    take_action_ocimem_b = 1'b0;
    chipselect = 1'b0; read = 1'b0;
    #1;
    check_reset_outputs("reset_mid_async");
    step();
    step();
    check_reset_outputs("reset_mid_held");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    exp_mona = '0;
    exp_mond = '0;
    checks++;
    if (wren_cnt != w0 || MonAReg !== 8'h0 || monitor_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_write: wrens=%0d a=%h rdy=%b, want 0 00 0",
               wren_cnt - w0, MonAReg, monitor_ready);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = $urandom;
    exp_mem[8'h05] = 32'hDEAD_BEEF;
    bd_load = 1'b1;
    step();
    bd_load = 1'b0;
    test_reset();
    test_load_read();
    test_write_wrap();
    test_cpu_read();
    test_cpu_write();
    test_random_jtag();
    test_conflict();
    test_image();
    test_reset_mid();
    test_image();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
